tick_interval_monitor: RTL and testbench
========================================

Name: tick_interval_monitor

Overview:
- Receiver-side counterpart of the periodic one-cycle tick generator.
- Consumes a single-cycle tick pulse stream and measures the clock count between consecutive ticks.
- Flags each measured interval as in or out of tolerance against an expected period, and raises a sticky timeout when ticks stop.
- Used to supervise heartbeat/timer pulses inside the SDIO FPGA design.

Parameters:
EXPECTED_PERIOD, 100, nominal clocks between ticks.
TOLERANCE, 2, allowed absolute deviation from EXPECTED_PERIOD (inclusive).
MAX_CLOCKS, 1000, longest accepted interval; must be greater than EXPECTED_PERIOD+TOLERANCE.
COUNT_WIDTH, 16, width of tick_count.

Ports:
clock  input  1  system clock, all logic on posedge.
reset  input  1  synchronous, active-high reset.
tick_in  input  1  tick pulse, one cycle high per event; back-to-back highs are separate ticks.
timeout_clear  input  1  one-cycle request to clear the sticky timeout.
period_out  output  $clog2(MAX_CLOCKS+1)  last measured interval in clocks.
period_valid  output  1  one-cycle strobe, period_out/period_ok updated.
period_ok  output  1  last interval within EXPECTED_PERIOD±TOLERANCE.
timeout  output  1  sticky: no tick within MAX_CLOCKS.
tick_count  output  COUNT_WIDTH  ticks seen since reset, saturating at all ones.

Behaviour:
- All outputs are registered.
- Reset values: period_out=0, period_valid=0, period_ok=0, timeout=0, tick_count=0, internal counter=0, state=IDLE.
- Reset has priority over every other input in any state, including mid-measurement.
- Internal counter width is $clog2(MAX_CLOCKS+1)+1; its value never exceeds MAX_CLOCKS.
- Every sampled tick_in=1 increments tick_count; it holds at 2^COUNT_WIDTH-1 and does not wrap.
- States: IDLE (no reference tick yet), MEASURING, TIMEOUT.
- IDLE:
  - tick_in=1 -> MEASURING, counter<=1, period_valid stays 0.
  - tick_in=0 -> no change.
- MEASURING, counter increments each cycle:
  - Interval definition: ticks sampled at edges t0 and t0+P give counter==P at the second edge.
  - On tick_in=1: period_out<=counter, period_valid<=1 for exactly the next cycle, period_ok<=(|counter-EXPECTED_PERIOD|<=TOLERANCE), counter<=1, stay in MEASURING.
  - Compute the deviation as unsigned difference using a compare-then-subtract; no signed wrap.
  - On tick_in=0 with counter==MAX_CLOCKS: timeout<=1, state->TIMEOUT, counter holds. period_out and period_ok are unchanged.
  - Tick and MAX_CLOCKS on the same edge: the tick wins. period_out=MAX_CLOCKS is a valid measurement with no timeout.
- TIMEOUT:
  - tick_in=1 -> MEASURING, counter<=1, no period_valid (interval unknown). timeout remains set.
- timeout_clear=1 clears timeout in any state.
  - If timeout sets on the same edge as timeout_clear, set wins.
- Latency: period_valid, period_out, period_ok and tick_count update on the edge that samples the tick and are visible the following cycle.
- period_out and period_ok hold their values between strobes.

Test Plan:
- Drive ticks every 100 clocks for 5 ticks -> 4 period_valid strobes, each period_out=100, period_ok=1; tick_count=5; timeout=0.
- Intervals of 102, then 103, then 97 clocks -> period_ok = 1, 0, 0; period_out = 102, 103, 97.
- Single tick, then tick_in held low -> timeout rises exactly 1000 clocks after the tick edge; a later tick gives no strobe; the following interval of 100 gives period_out=100 with timeout still 1; a timeout_clear pulse drops it to 0.
- Second tick exactly 1000 clocks after the first -> period_valid with period_out=1000, period_ok=0, timeout stays 0. Ticks on two consecutive cycles -> period_out=1.
- Assert reset for one cycle at counter≈50 in MEASURING -> all outputs 0, state IDLE. The next tick produces no strobe; the tick after it measures correctly.
- COUNT_WIDTH=3 with 10 ticks -> tick_count saturates at 7.

Source files
------------

// File: rtl/tick_interval_monitor.sv
// tick_interval_monitor
//   Receiver-side supervisor for a periodic one-cycle tick stream. It measures the
//   number of clocks between consecutive ticks and flags each interval as in or out
//   of tolerance. If ticks stop arriving, it raises a sticky timeout. It also keeps
//   a saturating count of all ticks seen.
//
// Ports
//   clock          in   system clock, all logic on posedge
//   reset          in   synchronous, active-high reset
//   tick_in        in   tick pulse; every high cycle is a separate tick
//   timeout_clear  in   one-cycle request to clear the sticky timeout
//   period_out     out  last measured interval in clocks
//   period_valid   out  one-cycle strobe when period_out/period_ok update
//   period_ok      out  last interval within EXPECTED_PERIOD +/- TOLERANCE
//   timeout        out  sticky: no tick within MAX_CLOCKS
//   tick_count     out  ticks seen since reset, saturating at all ones
module tick_interval_monitor #(
  parameter int unsigned EXPECTED_PERIOD = 100,
  parameter int unsigned TOLERANCE       = 2,
  parameter int unsigned MAX_CLOCKS      = 1000,
  parameter int unsigned COUNT_WIDTH     = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             tick_in,
  input  logic                             timeout_clear,
  output logic [$clog2(MAX_CLOCKS+1)-1:0] period_out,
  output logic                             period_valid,
  output logic                             period_ok,
  output logic                             timeout,
  output logic [COUNT_WIDTH-1:0]           tick_count
);

  localparam int unsigned PeriodWidth  = $clog2(MAX_CLOCKS + 1);
  localparam int unsigned CounterWidth = PeriodWidth + 1;

  localparam logic [CounterWidth-1:0] ExpectedC = CounterWidth'(EXPECTED_PERIOD);
  localparam logic [CounterWidth-1:0] TolC      = CounterWidth'(TOLERANCE);
  localparam logic [CounterWidth-1:0] MaxC      = CounterWidth'(MAX_CLOCKS);

  typedef enum logic [1:0] {
    StIdle,
    StMeasuring,
    StTimeout
  } state_e;

  state_e                     state_q;
  logic [CounterWidth-1:0]    counter_q;
  logic [PeriodWidth-1:0]     period_q;
  logic                       valid_q;
  logic                       ok_q;
  logic                       timeout_q;
  logic [COUNT_WIDTH-1:0]     tick_count_q;

  // Absolute deviation of the running interval from the nominal period.
  // Compare first so the subtraction never wraps.
  logic [CounterWidth-1:0]    deviation;
  logic                       in_tolerance;

  always_comb begin
    deviation = '0;
    if (counter_q >= ExpectedC) begin
      deviation = counter_q - ExpectedC;
    end else begin
      deviation = ExpectedC - counter_q;
    end
    in_tolerance = (deviation <= TolC);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      counter_q    <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      ok_q         <= 1'b0;
      timeout_q    <= 1'b0;
      tick_count_q <= '0;
    end else begin
      valid_q <= 1'b0;

      if (tick_in && (tick_count_q != {COUNT_WIDTH{1'b1}})) begin
        tick_count_q <= tick_count_q + COUNT_WIDTH'(1);
      end

      // Clear first; a timeout detected on this same edge overrides it below.
      if (timeout_clear) begin
        timeout_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (tick_in) begin
            state_q   <= StMeasuring;
            counter_q <= CounterWidth'(1);
          end
        end

        StMeasuring: begin
          // A tick landing exactly on MAX_CLOCKS is a valid measurement.
          if (tick_in) begin
            period_q  <= counter_q[PeriodWidth-1:0];
            valid_q   <= 1'b1;
            ok_q      <= in_tolerance;
            counter_q <= CounterWidth'(1);
          end else if (counter_q == MaxC) begin
            timeout_q <= 1'b1;
            state_q   <= StTimeout;
          end else begin
            counter_q <= counter_q + CounterWidth'(1);
          end
        end

        StTimeout: begin
          // The interval since the last tick is unknown, so no strobe here.
          if (tick_in) begin
            state_q   <= StMeasuring;
            counter_q <= CounterWidth'(1);
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign period_out   = period_q;
  assign period_valid = valid_q;
  assign period_ok    = ok_q;
  assign timeout      = timeout_q;
  assign tick_count   = tick_count_q;

endmodule

// File: tb/tb_tick_interval_monitor.sv
// Directed testbench for tick_interval_monitor.
// It runs a default-parameter instance and a COUNT_WIDTH=3 instance side by side.
module tb_tick_interval_monitor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tick_in = 1'b0;
  logic        timeout_clear = 1'b0;

  logic [9:0]  period_out;
  logic        period_valid;
  logic        period_ok;
  logic        timeout;
  logic [15:0] tick_count;

  logic [9:0]  s_period_out;
  logic        s_period_valid;
  logic        s_period_ok;
  logic        s_timeout;
  logic [2:0]  s_tick_count;

  int n_cmp    = 0;
  int n_err    = 0;
  int n_strobe = 0;
  int strobe_mark;

  always #5 clock = ~clock;

  tick_interval_monitor u_dut (
    .clock         (clock),
    .reset         (reset),
    .tick_in       (tick_in),
    .timeout_clear (timeout_clear),
    .period_out    (period_out),
    .period_valid  (period_valid),
    .period_ok     (period_ok),
    .timeout       (timeout),
    .tick_count    (tick_count)
  );

  tick_interval_monitor #(
    .COUNT_WIDTH (3)
  ) u_dut_small (
    .clock         (clock),
    .reset         (reset),
    .tick_in       (tick_in),
    .timeout_clear (timeout_clear),
    .period_out    (s_period_out),
    .period_valid  (s_period_valid),
    .period_ok     (s_period_ok),
    .timeout       (s_timeout),
    .tick_count    (s_tick_count)
  );

  always @(posedge clock) begin
    if (period_valid) n_strobe <= n_strobe + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Step one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    tick_in = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // One-cycle tick. On return, the results of the sampling edge are visible.
  task automatic pulse();
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
  endtask

  task automatic expect_period(input string tag, input int p, input logic ok);
    check({tag, ".valid"}, 32'(period_valid), 32'd1);
    check({tag, ".period"}, 32'(period_out), 32'(p));
    check({tag, ".ok"}, 32'(period_ok), 32'(ok));
  endtask

  initial begin
    // Reset.
    step();
    step();
    reset = 1'b0;
    check("rst.period", 32'(period_out), 32'd0);
    check("rst.valid", 32'(period_valid), 32'd0);
    check("rst.ok", 32'(period_ok), 32'd0);
    check("rst.timeout", 32'(timeout), 32'd0);
    check("rst.count", 32'(tick_count), 32'd0);

    // Five ticks, 100 clocks apart.
    strobe_mark = n_strobe;
    pulse();
    check("nom.first_no_strobe", 32'(period_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      idle(99);
      pulse();
      expect_period("nom", 100, 1'b1);
    end
    step();
    check("nom.strobe_one_cycle", 32'(period_valid), 32'd0);
    check("nom.strobes", 32'(n_strobe - strobe_mark), 32'd4);
    check("nom.count", 32'(tick_count), 32'd5);
    check("nom.timeout", 32'(timeout), 32'd0);

    // Tolerance boundaries. The previous tick was one extra step ago.
    idle(100);
    pulse();
    expect_period("tol102", 102, 1'b1);
    idle(102);
    pulse();
    expect_period("tol103", 103, 1'b0);
    idle(96);
    pulse();
    expect_period("tol97", 97, 1'b0);
    check("tol.count", 32'(tick_count), 32'd8);

    // Timeout fires exactly 1000 clocks after the last tick edge.
    idle(999);
    check("to.not_yet", 32'(timeout), 32'd0);
    idle(1);
    check("to.set", 32'(timeout), 32'd1);
    check("to.period_hold", 32'(period_out), 32'd97);
    check("to.ok_hold", 32'(period_ok), 32'd0);
    idle(5);
    pulse();
    check("to.resume_no_strobe", 32'(period_valid), 32'd0);
    check("to.sticky", 32'(timeout), 32'd1);
    idle(99);
    pulse();
    expect_period("to.after", 100, 1'b1);
    check("to.still_set", 32'(timeout), 32'd1);
    timeout_clear = 1'b1;
    step();
    timeout_clear = 1'b0;
    check("to.cleared", 32'(timeout), 32'd0);

    // Tick exactly at MAX_CLOCKS wins over timeout; then back-to-back ticks.
    pulse();
    idle(999);
    pulse();
    expect_period("max", 1000, 1'b0);
    check("max.no_timeout", 32'(timeout), 32'd0);
    pulse();
    expect_period("b2b", 1, 1'b0);

    // Reset mid-measurement.
    idle(49);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid.period", 32'(period_out), 32'd0);
    check("mid.valid", 32'(period_valid), 32'd0);
    check("mid.ok", 32'(period_ok), 32'd0);
    check("mid.timeout", 32'(timeout), 32'd0);
    check("mid.count", 32'(tick_count), 32'd0);
    idle(3);
    pulse();
    check("mid.first_no_strobe", 32'(period_valid), 32'd0);
    check("mid.count1", 32'(tick_count), 32'd1);
    idle(99);
    pulse();
    expect_period("mid.next", 100, 1'b1);

    // Saturation of a 3-bit tick count.
    check("sat.small_before", 32'(s_tick_count), 32'd2);
    for (int k = 0; k < 10; k++) begin
      pulse();
      idle(1);
    end
    check("sat.small", 32'(s_tick_count), 32'd7);
    check("sat.big", 32'(tick_count), 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
